// File: rtl/barrel_shift_checker.sv
// Response checker for barrel_shift: recomputes the shift one bit per cycle and
// keeps saturating check/error counters. Optional first-error capture: BSC_FIRST_ERR_EN.
module barrel_shift_checker #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic             s_dir,
    input  logic [SHW-1:0]   s_shamt,
    input  logic [WIDTH-1:0] s_out,
    input  logic             clr,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count
`ifdef BSC_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0] fe_in,
    output logic             fe_dir,
    output logic [SHW-1:0]   fe_shamt,
    output logic [WIDTH-1:0] fe_out,
    output logic [WIDTH-1:0] fe_exp
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, CMP} state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t           st;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] r_out;
    logic             r_dir;
    logic [SHW-1:0]   cnt;
`ifdef BSC_FIRST_ERR_EN
    logic [WIDTH-1:0] r_in;
    logic [SHW-1:0]   r_shamt;
`endif

    logic miss;
    assign miss = (exp_q != r_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            s_ready   <= 1'b1;
            exp_q     <= '0;
            r_out     <= '0;
            r_dir     <= 1'b0;
            cnt       <= '0;
            mismatch  <= 1'b0;
            fail      <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
`ifdef BSC_FIRST_ERR_EN
            r_in      <= '0;
            r_shamt   <= '0;
            fe_in     <= '0;
            fe_dir    <= 1'b0;
            fe_shamt  <= '0;
            fe_out    <= '0;
            fe_exp    <= '0;
`endif
        end else begin
            mismatch <= 1'b0;
            case (st)
                IDLE: if (s_valid) begin
                    exp_q   <= s_in;
                    cnt     <= s_shamt;
                    r_dir   <= s_dir;
                    r_out   <= s_out;
`ifdef BSC_FIRST_ERR_EN
                    r_in    <= s_in;
                    r_shamt <= s_shamt;
`endif
                    s_ready <= 1'b0;
                    st      <= (s_shamt == '0) ? CMP : SHIFT;
                end
                SHIFT: begin
                    exp_q <= r_dir ? (exp_q >> 1) : (exp_q << 1);
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHW'(1)) st <= CMP;
                end
                CMP: begin
                    st       <= IDLE;
                    s_ready  <= 1'b1;
                    mismatch <= miss;
                    if (chk_count != CMAX) chk_count <= chk_count + 1'b1;
                    if (miss) begin
                        if (err_count != CMAX) err_count <= err_count + 1'b1;
                        fail <= 1'b1;
`ifdef BSC_FIRST_ERR_EN
                        if (!fail) begin
                            fe_in    <= r_in;
                            fe_dir   <= r_dir;
                            fe_shamt <= r_shamt;
                            fe_out   <= r_out;
                            fe_exp   <= exp_q;
                        end
`endif
                    end
                end
                default: st <= IDLE;
            endcase
            // clr overrides any same-edge compare update; the mismatch pulse survives
            if (clr) begin
                chk_count <= '0;
                err_count <= '0;
                fail      <= 1'b0;
`ifdef BSC_FIRST_ERR_EN
                fe_in     <= '0;
                fe_dir    <= 1'b0;
                fe_shamt  <= '0;
                fe_out    <= '0;
                fe_exp    <= '0;
`endif
            end
        end
    end
endmodule
